// File: rtl/uartrx.sv
// 8N1 UART receiver with mid-bit sampling and a go/dr acknowledge handshake.
// Define UARTRX_OVERRUN_EN to add the sticky ovr output for frames lost while awaiting acknowledge.
module uartrx #(
    parameter int unsigned ClockFrequencyHz = 66_000_000,
    parameter int unsigned BaudRate         = 9600
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic       go,
    output logic [7:0] data,
    output logic       dr,
    output logic       ferr
`ifdef UARTRX_OVERRUN_EN
    ,
    output logic       ovr
`endif
);

    localparam int unsigned BitTime = ClockFrequencyHz / BaudRate;
    localparam int unsigned TimeW   = $clog2(BitTime);

    localparam logic [TimeW-1:0] HalfLoad = TimeW'(BitTime / 2 - 1);
    localparam logic [TimeW-1:0] FullLoad = TimeW'(BitTime - 1);

    typedef enum logic [2:0] {
        Idle,
        StartBit,
        DataBits,
        StopBit,
        WaitForGoLow
    } state_e;

    state_e            state_q;
    logic [TimeW-1:0]  time_q;
    logic [2:0]        bit_q;
    logic [7:0]        data_q;
    logic              ferr_q;
    logic              rx_meta_q;
    logic              rx_s_q;
    logic              rx_p_q;
    logic              fall;
    logic              time_zero;
`ifdef UARTRX_OVERRUN_EN
    logic              ovr_q;
`endif

    assign fall      = rx_p_q & ~rx_s_q;
    assign time_zero = (time_q == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= Idle;
            time_q    <= '0;
            bit_q     <= '0;
            data_q    <= '0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            rx_p_q    <= 1'b1;
`ifdef UARTRX_OVERRUN_EN
            ovr_q     <= 1'b0;
`endif
        end else begin
            rx_meta_q <= rx;
            rx_s_q    <= rx_meta_q;
            rx_p_q    <= rx_s_q;

            unique case (state_q)
                Idle: begin
                    if (go && fall) begin
                        time_q  <= HalfLoad;
                        state_q <= StartBit;
                    end
                end
                StartBit: begin
                    if (!time_zero) begin
                        time_q <= time_q - 1'b1;
                    end else if (!rx_s_q) begin
                        time_q  <= FullLoad;
                        bit_q   <= '0;
                        state_q <= DataBits;
`ifdef UARTRX_OVERRUN_EN
                        ovr_q   <= 1'b0;
`endif
                    end else begin
                        // Start bit no longer low at mid-bit: treat as a line glitch.
                        state_q <= Idle;
                    end
                end
                DataBits: begin
                    if (!time_zero) begin
                        time_q <= time_q - 1'b1;
                    end else begin
                        data_q[bit_q] <= rx_s_q;
                        bit_q         <= bit_q + 3'd1;
                        time_q        <= FullLoad;
                        if (bit_q == 3'd7) begin
                            state_q <= StopBit;
                        end
                    end
                end
                StopBit: begin
                    if (!time_zero) begin
                        time_q <= time_q - 1'b1;
                    end else begin
                        ferr_q  <= ~rx_s_q;
                        state_q <= WaitForGoLow;
                    end
                end
                WaitForGoLow: begin
                    if (!go) begin
                        state_q <= Idle;
                    end
`ifdef UARTRX_OVERRUN_EN
                    if (fall) begin
                        ovr_q <= 1'b1;
                    end
`endif
                end
                default: state_q <= Idle;
            endcase
        end
    end

    assign data = data_q;
    assign ferr = ferr_q;
    assign dr   = (state_q == WaitForGoLow);
`ifdef UARTRX_OVERRUN_EN
    assign ovr  = ovr_q;
`endif

endmodule

// File: tb/tb_uartrx.sv
// Scoreboard bench for uartrx: stimulus pushes expected bytes, a monitor pops them on each dr rise.
// Build with UARTRX_OVERRUN_EN defined to also check the ovr output.
module tb_uartrx;

    localparam int unsigned BitTime = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic       go = 1'b0;
    logic [7:0] data;
    logic       dr;
    logic       ferr;
`ifdef UARTRX_OVERRUN_EN
    logic       ovr;
`endif

    uartrx #(
        .ClockFrequencyHz(16),
        .BaudRate        (1)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .rx   (rx),
        .go   (go),
        .data (data),
        .dr   (dr),
        .ferr (ferr)
`ifdef UARTRX_OVERRUN_EN
        ,
        .ovr  (ovr)
`endif
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad = 0;
    int unsigned cyc = 0;
    int unsigned fall_cyc = 0;
    int unsigned rise_cyc = 0;
    logic [8:0]  exp_q[$];
    logic [8:0]  mon_e;
    logic        dr_d = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every rising dr must match the oldest expected {ferr, data}.
    always @(negedge clk) begin
        if (rst_n && dr && !dr_d) begin
            rise_cyc = cyc;
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_dr: got byte %0h expected no byte", data);
            end else begin
                mon_e = exp_q.pop_front();
                check("data", {24'd0, data}, {24'd0, mon_e[7:0]});
                check("ferr", {31'd0, ferr}, {31'd0, mon_e[8]});
            end
        end
        dr_d = dr;
    end

    task automatic send_frame(input logic [7:0] b, input logic stop, input logic expect_rx);
        if (expect_rx) exp_q.push_back({~stop, b});
        @(negedge clk);
        rx = 1'b0;
        fall_cyc = cyc;
        for (int i = 0; i < 8; i++) begin
            repeat (BitTime) @(negedge clk);
            rx = b[i];
        end
        repeat (BitTime) @(negedge clk);
        rx = stop;
        repeat (BitTime) @(negedge clk);
        rx = 1'b1;
    endtask

    task automatic ack();
        int n = 0;
        while (!dr && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!dr) begin
            total++;
            bad++;
            $display("FAIL ack_timeout: got dr=0 expected dr=1 within 400 cycles");
        end else begin
            go = 1'b0;
            @(negedge clk);
            check("dr_after_ack", {31'd0, dr}, 32'd0);
            go = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("reset_dr", {31'd0, dr}, 32'd0);
        check("reset_data", {24'd0, data}, 32'd0);
        check("reset_ferr", {31'd0, ferr}, 32'd0);
`ifdef UARTRX_OVERRUN_EN
        check("reset_ovr", {31'd0, ovr}, 32'd0);
`endif
        rst_n = 1'b1;
        go = 1'b1;
        repeat (5) @(negedge clk);

        // Basic receive with latency check.
        send_frame(8'hA5, 1'b1, 1'b1);
        check("latency", rise_cyc - fall_cyc, 32'd155);
        ack();
        repeat (4) @(negedge clk);
        check("idle_dr", {31'd0, dr}, 32'd0);

        // Back-to-back.
        send_frame(8'h00, 1'b1, 1'b1);
        ack();
        send_frame(8'hFF, 1'b1, 1'b1);
        ack();

        // Glitch: short low pulse must not start a frame.
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (40) @(negedge clk);
        check("glitch_dr", {31'd0, dr}, 32'd0);

        // Framing error.
        send_frame(8'h3C, 1'b0, 1'b1);
        ack();

        // Handshake hold with a lost frame.
        send_frame(8'h55, 1'b1, 1'b1);
        send_frame(8'h12, 1'b1, 1'b0);
        repeat (40) @(negedge clk);
        check("hold_dr", {31'd0, dr}, 32'd1);
        check("hold_data", {24'd0, data}, 32'h55);
`ifdef UARTRX_OVERRUN_EN
        check("ovr_set", {31'd0, ovr}, 32'd1);
`endif
        ack();
        send_frame(8'h77, 1'b1, 1'b1);
`ifdef UARTRX_OVERRUN_EN
        check("ovr_clear", {31'd0, ovr}, 32'd0);
`endif
        ack();

        // Gating: go low ignores frames.
        go = 1'b0;
        send_frame(8'h81, 1'b1, 1'b0);
        repeat (20) @(negedge clk);
        check("gated_dr", {31'd0, dr}, 32'd0);
        go = 1'b1;
        repeat (4) @(negedge clk);

        // Reset during bit 3; go held low for the remainder of the aborted frame.
        fork
            send_frame(8'h9E, 1'b1, 1'b0);
            begin
                repeat (72) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                go = 1'b0;
                check("rst_dr", {31'd0, dr}, 32'd0);
                check("rst_data", {24'd0, data}, 32'd0);
            end
        join
        repeat (4) @(negedge clk);
        go = 1'b1;
        repeat (4) @(negedge clk);
        send_frame(8'h42, 1'b1, 1'b1);
        ack();

        repeat (10) @(negedge clk);
        check("sb_empty", exp_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/uartrx.md
Name: uartrx

Overview:
UART receiver and the receive-side counterpart of the team's UART transmitter. Decodes 8N1 frames (LSB first) from the asynchronous rx pin using mid-bit sampling. Presents each byte to the SoC I/O logic with the same go/acknowledge handshake the transmitter uses. Sits between the board rx pin and the memory-mapped UART register block.

Parameters:
ClockFrequencyHz, 66_000_000, system clock frequency in Hz
BaudRate, 9600, line rate in bit/s; BIT_TIME = ClockFrequencyHz / BaudRate (integer division); BIT_TIME >= 4 required

Ports:
clk  input  1  system clock
rst_n  input  1  reset, synchronous, active-low
rx  input  1  UART rx wire, asynchronous, idle high
go  input  1  high = receiving enabled; drop low after dr seen high to acknowledge byte
data  output  8  received byte; valid while dr high
dr  output  1  data ready; high while a received byte awaits acknowledge
ferr  output  1  framing error for the byte shown in data (stop bit sampled low); valid while dr high

Behaviour:
- Reset values: data=0, dr=0, ferr=0, state=Idle, bit counter=0, time counter=0; synchronizer flops reset to 1.
- rx passes through 2 flops (rx_s); a third flop holds rx_s of the previous cycle (rx_p). Every decision below uses rx_s only.
- Start detect: falling edge, rx_p==1 && rx_s==0. A line held low at reset or after acknowledge is not a start.
- States and transitions:
  - Idle: dr=0. If go && falling edge: time counter=BIT_TIME/2-1, go to StartBit. Else stay.
  - StartBit: decrement the time counter each cycle. At 0, sample rx_s:
    - 0: time counter=BIT_TIME-1, bit counter=0, go to DataBits.
    - 1: glitch; return to Idle with no output change.
  - DataBits: decrement each cycle. At 0: data[bit counter]<=rx_s, bit counter+1, time counter=BIT_TIME-1. After bit 7 is sampled, go to StopBit.
  - StopBit: decrement each cycle. At 0: ferr<=!rx_s, go to WaitForGoLow.
  - WaitForGoLow: dr=1 (combinational from state). When go==0, go to Idle; dr falls the same cycle the state leaves.
- Sample points fall at mid-bit: (BIT_TIME/2 + k*BIT_TIME) cycles after the first rx_s low, k=0..9.
- Latency: dr rises 1 cycle after the stop-bit sample. With the 2-cycle synchronizer, that is 2 + BIT_TIME/2 + 9*BIT_TIME + 1 cycles after the rx pin falls.
- data and ferr hold from the stop-bit sample until the next frame's first data-bit sample. data bits are written in place, so data is undefined while a new frame is in flight and is only meaningful while dr=1.
- go low in Idle: start edges are ignored.
- go dropping mid-frame: reception completes. dr then rises and falls on the following cycle because go is already low.
- Frames arriving while in WaitForGoLow are lost. After acknowledge, a frame already in progress is not picked up mid-bit; only a fresh falling edge starts reception.
- Time counter width: $clog2(BIT_TIME). Bit counter: 3 bits, with wrap-around from 7 to 0 acceptable.
- rst_n low in any state: return to Idle next edge with reset values; a partial byte is discarded.
- Single clock domain; no combinational path from rx to any output.

Optional Feature:
UARTRX_OVERRUN_EN
- Defined: adds output ovr (1 bit, reset 0).
  - ovr is set when a falling edge on rx_s is detected while state==WaitForGoLow.
  - ovr is cleared on the cycle a new frame's StartBit is validated.
  - ovr is sticky across the acknowledge.
- Undefined: no ovr port; lost frames are silent.

Test Plan:
Use ClockFrequencyHz=16, BaudRate=1 (BIT_TIME=16) for all scenarios.
- Basic receive: go=1, drive frame 0xA5 with stop=1. Required: dr rises 2+8+144+1=155 cycles after the rx fall; data=0xA5; ferr=0. Drop go: dr=0 next cycle. Raise go: state=Idle.
- Back-to-back: send 0x00 then 0xFF, acknowledging between them before the second start edge. Required: two dr pulses with data 0x00 then 0xFF, ferr=0 on both.
- Glitch and framing: a 4-cycle low pulse on rx produces no dr and a return to Idle. Frame 0x3C with stop bit low gives dr=1, data=0x3C, ferr=1.
- Handshake hold: receive 0x55 and keep go=1 for 200 more cycles while sending 0x12. Required: dr stays 1, data stays 0x55. After go low, a fresh 0x77 frame is received correctly. With UARTRX_OVERRUN_EN, ovr=1 after the 0x12 edge and clears at the start of 0x77.
- Gating and reset: with go=0, send 0x81 and expect no dr. Assert rst_n=0 for 1 cycle during bit 3 of frame 0x9E. Required: dr=0, data=0, and the next full frame 0x42 is received correctly.
